math_alu_sequencer: RTL and testbench
=====================================

// Module: math_alu_sequencer
// PURPOSE
//  Sequencer that shares one combinational math_adder_16bit (a, b, cin -> sum[16:0]) across calculator ops.
//  Accepts one op per start pulse: ADD, SUB (a + ~b + 1), or MUL (8x8 unsigned, shift-and-add, one adder pass/cycle).
//  Sits between the calculator FSM (issues start/op/operands) and the result display/register path.
// PARAMETERS
//  MUL_ITERS  8   multiplier bits consumed by MUL; fixed to 8 (8x8 -> 16-bit product, cannot overflow)
// PORTS
//  clk       in   1   single clock, rising edge
//  rst_n     in   1   asynchronous, active-low reset
//  start     in   1   request; sampled only when accepting (IDLE or DONE)
//  op        in   2   00 ADD, 01 SUB, 10 MUL, 11 reserved
//  opa       in   16  operand A (MUL uses opa[7:0] only)
//  opb       in   16  operand B (MUL uses opb[7:0] only)
//  busy      out  1   high while an op executes (EXEC or MUL states)
//  done      out  1   one-cycle pulse: result valid
//  result    out  16  op result; held until next accepted start
//  carry     out  1   ADD: sum[16]; SUB: sum[16] (1 = no borrow); MUL: 0
//  err       out  1   1 when the last accepted op was reserved (11)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, carry=0, err=0; internal regs cleared. Applies mid-op;
//   the op in flight is discarded with no done.
//  States: IDLE, EXEC, MUL, DONE.
//  IDLE/DONE: start=1 captures op/opa/opb in cycle N. ADD/SUB/reserved -> EXEC; MUL -> MUL (acc=0, mcand={8'h0,opa[7:0]},
//   mplier=opb[7:0], cnt=0). start=0: DONE -> IDLE, IDLE stays IDLE.
//  Back-to-back: a start in the DONE cycle is accepted. start in EXEC/MUL is ignored: no queueing, no error.
//  EXEC (cycle N+1): ADD: a=opa, b=opb, cin=0. SUB: a=opa, b=~opb, cin=1. result<=sum[15:0], carry<=sum[16], err<=0.
//   Reserved: result<=0, carry<=0, err<=1. -> DONE.
//  MUL (cycles N+1..N+8): adder a=acc, b=mcand, cin=0. If mplier[0], acc<=sum[15:0]; else acc unchanged.
//   Then mcand<<=1, mplier>>=1, cnt++. Fixed latency: no early exit on mplier==0.
//   After iteration MUL_ITERS, result<=acc, carry<=0, err<=0 -> DONE.
//  DONE: done=1 for exactly this cycle, busy=0.
//   Latency: start at N gives done at N+2 (ADD/SUB/reserved) or N+9 (MUL).
//  busy=1 exactly in EXEC/MUL cycles. result/carry/err keep their previous values until overwritten at completion.
//  Arithmetic is modulo 2^16. SUB borrow is signalled by carry=0. opa/opb may change after capture without effect.
//  When idle, the adder inputs are driven to 0 (no X propagation).
// STRUCTURE
//  Shared header/package math_defs: OP_ADD/OP_SUB/OP_MUL/OP_RSV encodings, state encodings, MUL_ITERS.
//  One sub-module: math_adder_16bit (existing, unchanged), instantiated once. Operand mux and FSM are local.
// TESTING
//  1 ADD 0x0FFF+0x0001, start at N -> result=0x1000, carry=0, err=0, done only at N+2, busy only at N+1.
//  2 ADD 0xFFFF+0xFFFF -> result=0xFFFE, carry=1; then SUB 0x0007-0x0005 -> 0x0002, carry=1;
//    then SUB 0x0005-0x0007 -> 0xFFFE, carry=0.
//  3 MUL opa=0xABFF, opb=0x12FF -> result=0xFE01 (upper bytes ignored), carry=0, done at N+9, busy N+1..N+8.
//    MUL 0x0000*0x00FF -> 0x0000, still done at N+9.
//  4 start(ADD 1+1) pulsed at N+3 during a MUL -> ignored; MUL result unchanged.
//    op=11 -> err=1, result=0, done at N+2; the next valid op clears err.
//  5 rst_n low for one cycle at MUL iteration 4 -> busy/done/result/carry/err=0 immediately, state IDLE,
//    no stray done; a following ADD 2+3 -> 0x0005.
//  6 Back-to-back: new start asserted in the DONE cycle of an ADD -> accepted; its done arrives 2 cycles later.

Source files
------------

// File: rtl/math_defs.sv
// Shared definitions for the calculator math path.
//   OP_*       : op encodings on the sequencer op input
//   ST_*       : sequencer FSM state encodings
//   MUL_ITERS  : multiplier bits consumed by MUL (8x8 -> 16-bit product)
package math_defs;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_MUL  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int unsigned MUL_ITERS = 8;

endpackage

// File: rtl/math_adder_16bit.sv
// Combinational 16-bit adder with carry in and carry out.
//   a, b : addends
//   cin  : carry in
//   sum  : {carry out, 16-bit sum}
module math_adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [16:0] sum
);

    assign sum = {1'b0, a} + {1'b0, b} + {16'b0, cin};

endmodule

// File: rtl/math_alu_sequencer.sv
// Sequencer sharing a single 16-bit adder across ADD, SUB and 8x8 shift-and-add MUL.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only in IDLE or DONE
//   op         : 00 ADD, 01 SUB, 10 MUL, 11 reserved
//   opa, opb   : operands (MUL uses the low bytes only)
//   busy       : high in EXEC/MUL
//   done       : one-cycle result-valid pulse
//   result     : op result, held until the next completion
//   carry      : adder carry out (SUB: 1 = no borrow); 0 for MUL
//   err        : last accepted op was reserved
module math_alu_sequencer
    import math_defs::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        carry,
    output logic        err
);

    localparam logic [3:0] CntLast = 4'(MUL_ITERS - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] opa_q, opa_d;
    logic [15:0] opb_q, opb_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] result_q, result_d;
    logic        carry_q, carry_d;
    logic        err_q, err_d;

    logic [15:0] add_a, add_b;
    logic        add_cin;
    logic [16:0] add_sum;
    logic [15:0] acc_next;

    math_adder_16bit u_adder (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (add_sum)
    );

    // Operand mux; held at zero outside EXEC/MUL so no X reaches the adder.
    always_comb begin
        add_a   = 16'h0;
        add_b   = 16'h0;
        add_cin = 1'b0;
        if (state_q == ST_EXEC) begin
            if (op_q == OP_ADD) begin
                add_a = opa_q;
                add_b = opb_q;
            end else if (op_q == OP_SUB) begin
                add_a   = opa_q;
                add_b   = ~opb_q;
                add_cin = 1'b1;
            end
        end else if (state_q == ST_MUL) begin
            add_a = acc_q;
            add_b = mcand_q;
        end
    end

    assign acc_next = mplier_q[0] ? add_sum[15:0] : acc_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    op_d  = op;
                    opa_d = opa;
                    opb_d = opb;
                    if (op == OP_MUL) begin
                        state_d  = ST_MUL;
                        acc_d    = 16'h0;
                        mcand_d  = {8'h0, opa[7:0]};
                        mplier_d = opb[7:0];
                        cnt_d    = 4'd0;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (op_q == OP_RSV) begin
                    result_d = 16'h0;
                    carry_d  = 1'b0;
                    err_d    = 1'b1;
                end else begin
                    result_d = add_sum[15:0];
                    carry_d  = add_sum[16];
                    err_d    = 1'b0;
                end
                state_d = ST_DONE;
            end
            ST_MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 4'd1;
                // Fixed latency: always run all iterations, even once mplier is zero.
                if (cnt_q == CntLast) begin
                    result_d = acc_next;
                    carry_d  = 1'b0;
                    err_d    = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            opa_q    <= 16'h0;
            opb_q    <= 16'h0;
            acc_q    <= 16'h0;
            mcand_q  <= 16'h0;
            mplier_q <= 8'h0;
            cnt_q    <= 4'd0;
            result_q <= 16'h0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q == ST_EXEC) || (state_q == ST_MUL);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign carry  = carry_q;
    assign err    = err_q;

endmodule

// File: tb/tb_math_alu_sequencer.sv
// Directed bench for math_alu_sequencer: latency, busy/done shape, arithmetic results,
// ignored starts, reserved op, mid-op reset and back-to-back issue.
module tb_math_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] opa;
    logic [15:0] opb;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry;
    logic        err;

    int checks;
    int failures;

    math_alu_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .opa    (opa),
        .opb    (opb),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge. Issues one op, then walks cycles N+1..N+lat checking busy/done
    // every cycle and the result at the done cycle. Returns at the negedge of the done cycle.
    // inject > 0 pulses an ADD 1+1 start during cycle N+inject (must be ignored).
    task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] b, input int lat, input int inject,
                          input logic [15:0] exp_res, input logic exp_c, input logic exp_e);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Operand changes after capture must not matter.
        opa   = 16'hDEAD;
        opb   = 16'hBEEF;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            start = (k == inject);
            if (k == inject) begin
                op  = 2'b00;
                opa = 16'h0001;
                opb = 16'h0001;
            end
            check_val({tag, " busy"}, busy, (k < lat));
            check_val({tag, " done"}, done, (k == lat));
        end
        start = 1'b0;
        check_val({tag, " result"}, result, exp_res);
        check_val({tag, " carry"}, carry, exp_c);
        check_val({tag, " err"}, err, exp_e);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        opa      = 16'h0;
        opb      = 16'h0;
        #1;
        check_val("rst busy", busy, 1'b0);
        check_val("rst done", done, 1'b0);
        check_val("rst result", result, 16'h0);
        check_val("rst carry", carry, 1'b0);
        check_val("rst err", err, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD / SUB
        run_op("add1", 2'b00, 16'h0FFF, 16'h0001, 2, 0, 16'h1000, 1'b0, 1'b0);
        @(negedge clk);
        run_op("add2", 2'b00, 16'hFFFF, 16'hFFFF, 2, 0, 16'hFFFE, 1'b1, 1'b0);
        @(negedge clk);
        run_op("sub1", 2'b01, 16'h0007, 16'h0005, 2, 0, 16'h0002, 1'b1, 1'b0);
        @(negedge clk);
        run_op("sub2", 2'b01, 16'h0005, 16'h0007, 2, 0, 16'hFFFE, 1'b0, 1'b0);
        @(negedge clk);

        // MUL: upper bytes ignored, fixed latency even for a zero multiplicand
        run_op("mul1", 2'b10, 16'hABFF, 16'h12FF, 9, 0, 16'hFE01, 1'b0, 1'b0);
        @(negedge clk);
        run_op("mul0", 2'b10, 16'h0000, 16'h00FF, 9, 0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);

        // Start during MUL at N+3 is ignored
        run_op("mulign", 2'b10, 16'h0003, 16'h0005, 9, 3, 16'h000F, 1'b0, 1'b0);
        @(negedge clk);
        check_val("mulign idle", busy, 1'b0);

        // Reserved op, then a valid op clears err
        run_op("rsv", 2'b11, 16'h1234, 16'h5678, 2, 0, 16'h0000, 1'b0, 1'b1);
        @(negedge clk);
        run_op("clrerr", 2'b00, 16'h8000, 16'h8001, 2, 0, 16'h0001, 1'b1, 1'b0);
        @(negedge clk);

        // Mid-MUL reset at iteration 4
        start = 1'b1;
        op    = 2'b10;
        opa   = 16'h0010;
        opb   = 16'h0010;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_val("pre-rst busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("midrst busy", busy, 1'b0);
        check_val("midrst done", done, 1'b0);
        check_val("midrst result", result, 16'h0);
        check_val("midrst carry", carry, 1'b0);
        check_val("midrst err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_val("postrst done", done, 1'b0);
            check_val("postrst busy", busy, 1'b0);
        end
        run_op("add23", 2'b00, 16'h0002, 16'h0003, 2, 0, 16'h0005, 1'b0, 1'b0);
        @(negedge clk);

        // Back-to-back: second start issued in the DONE cycle of the first
        run_op("b2b1", 2'b00, 16'h1111, 16'h2222, 2, 0, 16'h3333, 1'b0, 1'b0);
        run_op("b2b2", 2'b01, 16'h0010, 16'h0001, 2, 0, 16'h000F, 1'b1, 1'b0);
        @(negedge clk);
        check_val("final done", done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
